// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter:
// funct3 codes, memory write codes, FSM states and owners.
package dmem_pkg;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   localparam logic [2:0] MEM_SB = 3'd0;
   localparam logic [2:0] MEM_SW = 3'd2;

   typedef enum logic {IDLE, SH2} state_e;
   typedef enum logic {CORE, LDR} owner_e;

   // Access size in bytes implied by the low funct3 bits.
   function automatic logic [2:0] acc_size(input logic [2:0] f3);
      unique case (f3[1:0])
         2'd0:    acc_size = 3'd1;
         2'd1:    acc_size = 3'd2;
         default: acc_size = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Big-endian load extraction: picks the leading byte/half/word
// of the memory word and sign- or zero-extends it.
module load_extend
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] word_i,
   output logic [31:0] result_o
);

   // Extension selected by the load funct3; illegal codes give 0.
   always_comb begin
      result_o = '0;
      unique case (funct3_i)
         LB:      result_o = {{24{word_i[31]}}, word_i[31:24]};
         LH:      result_o = {{16{word_i[31]}}, word_i[31:16]};
         LW:      result_o = word_i;
         LBU:     result_o = {24'b0, word_i[31:24]};
         LHU:     result_o = {16'b0, word_i[31:16]};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between core and loader: grants with
// bounded loader starvation, checks accesses, splits sh.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MEM_BYTES  = 1024,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CORE_REQ,
   input  logic        CORE_WE,
   input  logic [2:0]  CORE_FUNCT3,
   input  logic [31:0] CORE_ADDR,
   input  logic [31:0] CORE_WDATA,
   output logic        CORE_GNT,
   output logic        CORE_RVALID,
   output logic [31:0] CORE_RDATA,
   output logic        CORE_ERR,
   input  logic        LDR_REQ,
   input  logic        LDR_WE,
   input  logic [31:0] LDR_ADDR,
   input  logic [31:0] LDR_WDATA,
   output logic        LDR_GNT,
   output logic        LDR_RVALID,
   output logic [31:0] LDR_RDATA,
   output logic        LDR_ERR,
   output logic        MEM_WE,
   output logic [2:0]  MEM_FUNCT3,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   starve_q, starve_d;
   logic [31:0]        sh_addr_q, sh_addr_d;
   logic [7:0]         sh_lo_q, sh_lo_d;
   logic               core_rvalid_q, core_rvalid_d;
   logic               core_err_q, core_err_d;
   logic [31:0]        core_rdata_q, core_rdata_d;
   logic               ldr_rvalid_q, ldr_rvalid_d;
   logic               ldr_err_q, ldr_err_d;
   logic [31:0]        ldr_rdata_q, ldr_rdata_d;

   logic               force_ldr, core_win;
   logic               core_gnt, ldr_gnt, any_gnt;
   logic               sel_we;
   logic [2:0]         sel_f3;
   logic [31:0]        sel_addr, sel_wdata;
   logic [2:0]         sz;
   logic [32:0]        end_addr;
   logic               ill, mis, oor, acc_err;
   logic [31:0]        ld_ext;

   // Arbitration: core first unless the loader has waited too long.
   always_comb begin
      force_ldr = LDR_REQ && (starve_q == CNT_W'(STARVE_MAX));
      core_win  = CORE_REQ && !force_ldr;
      core_gnt  = RST_N && (state_q == IDLE) && core_win;
      ldr_gnt   = RST_N && (state_q == IDLE) && LDR_REQ && !core_win;
      any_gnt   = core_gnt || ldr_gnt;
      sel_we    = core_gnt ? CORE_WE     : LDR_WE;
      sel_f3    = core_gnt ? CORE_FUNCT3 : LW;
      sel_addr  = core_gnt ? CORE_ADDR   : LDR_ADDR;
      sel_wdata = core_gnt ? CORE_WDATA  : LDR_WDATA;
   end

   // Legality, alignment and range check of the selected request.
   always_comb begin
      sz       = acc_size(sel_f3);
      ill      = core_gnt && ((sel_f3 inside {3'd3, 3'd6, 3'd7})
                 || (sel_we && sel_f3[2]));
      mis      = ((sz == 3'd2) && sel_addr[0])
                 || ((sz == 3'd4) && (sel_addr[1:0] != 2'b00));
      end_addr = {1'b0, sel_addr} + 33'(sz);
      oor      = end_addr > 33'(MEM_BYTES);
      acc_err  = ill || mis || oor;
   end

   load_extend u_ext (
      .funct3_i (sel_f3),
      .word_i   (MEM_RDATA),
      .result_o (ld_ext)
   );

   // FSM next state, memory drive and response capture.
   always_comb begin
      state_d       = state_q;
      sh_addr_d     = sh_addr_q;
      sh_lo_d       = sh_lo_q;
      core_rvalid_d = 1'b0;
      core_err_d    = 1'b0;
      core_rdata_d  = '0;
      ldr_rvalid_d  = 1'b0;
      ldr_err_d     = 1'b0;
      ldr_rdata_d   = '0;
      MEM_WE        = 1'b0;
      MEM_FUNCT3    = MEM_SW;
      MEM_ADDR      = sel_addr;
      MEM_WDATA     = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_we) begin
               if (sel_f3 == SW) begin
                  MEM_WDATA = sel_wdata;
               end else begin
                  MEM_FUNCT3 = MEM_SB;
                  MEM_WDATA  = {24'b0, (sel_f3 == SH) ?
                                sel_wdata[15:8] : sel_wdata[7:0]};
               end
            end
            MEM_WE = any_gnt && sel_we && !acc_err;
            if (MEM_WE && (sel_f3 == SH)) begin
               state_d   = SH2;
               sh_addr_d = sel_addr;
               sh_lo_d   = sel_wdata[7:0];
            end else if (core_gnt) begin
               core_rvalid_d = 1'b1;
               core_err_d    = acc_err;
               core_rdata_d  = (acc_err || sel_we) ? '0 : ld_ext;
            end else if (ldr_gnt) begin
               ldr_rvalid_d = 1'b1;
               ldr_err_d    = acc_err;
               ldr_rdata_d  = (acc_err || sel_we) ? '0 : ld_ext;
            end
         end
         SH2: begin
            MEM_WE        = RST_N;
            MEM_FUNCT3    = MEM_SB;
            MEM_ADDR      = sh_addr_q + 32'd1;
            MEM_WDATA     = {24'b0, sh_lo_q};
            state_d       = IDLE;
            core_rvalid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Starvation counter: counts core wins while the loader waits.
   always_comb begin
      starve_d = starve_q;
      if (!LDR_REQ || ldr_gnt) begin
         starve_d = '0;
      end else if (core_gnt && (starve_q != CNT_W'(STARVE_MAX))) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q       <= IDLE;
         starve_q      <= '0;
         sh_addr_q     <= '0;
         sh_lo_q       <= '0;
         core_rvalid_q <= 1'b0;
         core_err_q    <= 1'b0;
         core_rdata_q  <= '0;
         ldr_rvalid_q  <= 1'b0;
         ldr_err_q     <= 1'b0;
         ldr_rdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         starve_q      <= starve_d;
         sh_addr_q     <= sh_addr_d;
         sh_lo_q       <= sh_lo_d;
         core_rvalid_q <= core_rvalid_d;
         core_err_q    <= core_err_d;
         core_rdata_q  <= core_rdata_d;
         ldr_rvalid_q  <= ldr_rvalid_d;
         ldr_err_q     <= ldr_err_d;
         ldr_rdata_q   <= ldr_rdata_d;
      end
   end

   assign CORE_GNT    = core_gnt;
   assign LDR_GNT     = ldr_gnt;
   assign CORE_RVALID = core_rvalid_q;
   assign CORE_ERR    = core_err_q;
   assign CORE_RDATA  = core_rdata_q;
   assign LDR_RVALID  = ldr_rvalid_q;
   assign LDR_ERR     = ldr_err_q;
   assign LDR_RDATA   = ldr_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-array memory model,
// directed cases, arbitration pattern, random traffic, reset.
module tb_dmem_arbiter;

   localparam int MEM_BYTES = 1024;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        CORE_REQ, CORE_WE;
   logic [2:0]  CORE_FUNCT3;
   logic [31:0] CORE_ADDR, CORE_WDATA;
   logic        CORE_GNT, CORE_RVALID, CORE_ERR;
   logic [31:0] CORE_RDATA;
   logic        LDR_REQ, LDR_WE;
   logic [31:0] LDR_ADDR, LDR_WDATA;
   logic        LDR_GNT, LDR_RVALID, LDR_ERR;
   logic [31:0] LDR_RDATA;
   logic        MEM_WE;
   logic [2:0]  MEM_FUNCT3;
   logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

   dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_MAX(4), .CNT_W(3)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .CORE_REQ(CORE_REQ), .CORE_WE(CORE_WE),
      .CORE_FUNCT3(CORE_FUNCT3), .CORE_ADDR(CORE_ADDR),
      .CORE_WDATA(CORE_WDATA), .CORE_GNT(CORE_GNT),
      .CORE_RVALID(CORE_RVALID), .CORE_RDATA(CORE_RDATA),
      .CORE_ERR(CORE_ERR),
      .LDR_REQ(LDR_REQ), .LDR_WE(LDR_WE), .LDR_ADDR(LDR_ADDR),
      .LDR_WDATA(LDR_WDATA), .LDR_GNT(LDR_GNT),
      .LDR_RVALID(LDR_RVALID), .LDR_RDATA(LDR_RDATA),
      .LDR_ERR(LDR_ERR),
      .MEM_WE(MEM_WE), .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Environment memory seen by the DUT.
   logic [7:0] env_mem [MEM_BYTES] = '{default: 8'h00};
   logic [31:0] ma1, ma2, ma3;
   assign ma1 = MEM_ADDR + 32'd1;
   assign ma2 = MEM_ADDR + 32'd2;
   assign ma3 = MEM_ADDR + 32'd3;
   assign MEM_RDATA[31:24] = (MEM_ADDR < MEM_BYTES) ? env_mem[MEM_ADDR[9:0]] : 8'h00;
   assign MEM_RDATA[23:16] = (ma1 < MEM_BYTES) ? env_mem[ma1[9:0]] : 8'h00;
   assign MEM_RDATA[15:8]  = (ma2 < MEM_BYTES) ? env_mem[ma2[9:0]] : 8'h00;
   assign MEM_RDATA[7:0]   = (ma3 < MEM_BYTES) ? env_mem[ma3[9:0]] : 8'h00;

   always @(posedge CLK) begin
      if (MEM_WE) begin
         if (MEM_FUNCT3 == 3'd0) begin
            if (MEM_ADDR < MEM_BYTES) env_mem[MEM_ADDR[9:0]] <= MEM_WDATA[7:0];
         end else if (ma3 < MEM_BYTES) begin
            env_mem[MEM_ADDR[9:0]] <= MEM_WDATA[31:24];
            env_mem[ma1[9:0]]      <= MEM_WDATA[23:16];
            env_mem[ma2[9:0]]      <= MEM_WDATA[15:8];
            env_mem[ma3[9:0]]      <= MEM_WDATA[7:0];
         end
      end
   end

   // Reference memory updated at request acceptance.
   logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;
   exp_t q_core[$];
   exp_t q_ldr[$];

   int checks = 0;
   int failures = 0;

   logic        g_we;
   logic [2:0]  g_f3;
   logic [31:0] g_addr, g_wdata;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // Reference semantics: big-endian byte memory, size/alignment rules.
   task automatic model(input bit core, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err,
                        output logic [31:0] rd, output int lat);
      int sz;
      bit ill;
      logic [31:0] r;
      logic [9:0] idx;
      ill = core && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 >= 3'd4));
      case (f3[1:0])
         2'd0:    sz = 1;
         2'd1:    sz = 2;
         default: sz = 4;
      endcase
      err = ill || ((addr % 32'(sz)) != 0) || (longint'(addr) + sz > MEM_BYTES);
      rd  = '0;
      lat = 1;
      if (!err && we) begin
         for (int i = 0; i < sz; i++) begin
            idx = addr[9:0] + 10'(i);
            ref_mem[idx] = 8'(wdata >> (8 * (sz - 1 - i)));
         end
         if (sz == 2) lat = 2;
      end else if (!err) begin
         r = '0;
         for (int i = 0; i < sz; i++) begin
            idx = addr[9:0] + 10'(i);
            r = (r << 8) | 32'(ref_mem[idx]);
         end
         if (!f3[2] && sz < 4 && r[8*sz-1]) r = r | (32'hFFFFFFFF << (8 * sz));
         rd = r;
      end
   endtask

   task automatic on_gnt(input bit core);
      logic e;
      logic [31:0] d;
      int lat;
      exp_t x;
      if (core) model(1'b1, CORE_WE, CORE_FUNCT3, CORE_ADDR, CORE_WDATA, e, d, lat);
      else      model(1'b0, LDR_WE, 3'd2, LDR_ADDR, LDR_WDATA, e, d, lat);
      x.due = cyc + lat;
      x.err = e;
      x.data = d;
      if (core) q_core.push_back(x);
      else      q_ldr.push_back(x);
      g_we = MEM_WE;
      g_f3 = MEM_FUNCT3;
      g_addr = MEM_ADDR;
      g_wdata = MEM_WDATA;
   endtask

   // Monitor: pops the scoreboard whenever a response pulse appears.
   always @(negedge CLK) begin
      exp_t e;
      if (CORE_RVALID) begin
         if (q_core.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL core_unexpected_rvalid actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = q_core.pop_front();
            chk("core_latency", cyc, e.due);
            chk("core_err", {31'b0, CORE_ERR}, {31'b0, e.err});
            chk("core_rdata", CORE_RDATA, e.data);
         end
      end
      if (LDR_RVALID) begin
         if (q_ldr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ldr_unexpected_rvalid actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = q_ldr.pop_front();
            chk("ldr_latency", cyc, e.due);
            chk("ldr_err", {31'b0, LDR_ERR}, {31'b0, e.err});
            chk("ldr_rdata", LDR_RDATA, e.data);
         end
      end
   end

   // Issue one request; starts and ends just after a rising edge.
   task automatic issue(input bit core, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int waited);
      waited = 0;
      if (core) begin
         CORE_REQ = 1'b1; CORE_WE = we; CORE_FUNCT3 = f3;
         CORE_ADDR = addr; CORE_WDATA = wdata;
      end else begin
         LDR_REQ = 1'b1; LDR_WE = we; LDR_ADDR = addr; LDR_WDATA = wdata;
      end
      forever begin
         @(negedge CLK);
         if (core ? CORE_GNT : LDR_GNT) begin
            on_gnt(core);
            break;
         end
         waited++;
         if (waited > 20) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=%0d required=<=20", waited);
            break;
         end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      if (core) CORE_REQ = 1'b0;
      else      LDR_REQ = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      int r;
      r = int'($urandom % 20);
      if (r < 16)      return 32'($urandom % 64);
      else if (r < 19) return 32'(1016 + $urandom % 8);
      else             return $urandom;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int k;
      bit pc, pl;
      logic [7:0] old31;
      RST_N = 1'b0;
      CORE_REQ = 0; CORE_WE = 0; CORE_FUNCT3 = 0; CORE_ADDR = 0; CORE_WDATA = 0;
      LDR_REQ = 0; LDR_WE = 0; LDR_ADDR = 0; LDR_WDATA = 0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_core_rvalid", {31'b0, CORE_RVALID}, 0);
      chk("rst_ldr_rvalid", {31'b0, LDR_RVALID}, 0);
      chk("rst_core_err", {31'b0, CORE_ERR}, 0);
      chk("rst_core_rdata", CORE_RDATA, 0);
      chk("rst_ldr_rdata", LDR_RDATA, 0);
      chk("rst_mem_we", {31'b0, MEM_WE}, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;

      // Directed cases.
      issue(1, 1, 3'd2, 32'h10, 32'hA1B2C3D4, w);
      chk("sw_mem_we", {31'b0, g_we}, 1);
      chk("sw_mem_f3", {29'b0, g_f3}, 2);
      chk("sw_mem_wdata", g_wdata, 32'hA1B2C3D4);
      issue(1, 0, 3'd2, 32'h10, 0, w);
      issue(1, 1, 3'd1, 32'h22, 32'h0000BEEF, w);
      chk("sh1_addr", g_addr, 32'h22);
      chk("sh1_wdata", g_wdata, 32'hBE);
      chk("sh1_f3", {29'b0, g_f3}, 0);
      chk("sh1_we", {31'b0, g_we}, 1);
      @(negedge CLK);
      chk("sh2_addr", MEM_ADDR, 32'h23);
      chk("sh2_wdata", MEM_WDATA, 32'hEF);
      chk("sh2_we", {31'b0, MEM_WE}, 1);
      @(posedge CLK); #1;
      issue(1, 0, 3'd1, 32'h22, 0, w);
      issue(1, 0, 3'd5, 32'h22, 0, w);
      issue(1, 0, 3'd0, 32'h10, 0, w);
      issue(1, 0, 3'd4, 32'h10, 0, w);
      issue(1, 0, 3'd2, 32'h12, 0, w);
      issue(1, 1, 3'd1, 32'h21, 32'h1234, w);
      chk("sh_mis_we", {31'b0, g_we}, 0);
      issue(1, 0, 3'd2, 32'h3FE, 0, w);
      issue(1, 1, 3'd2, 32'h3FC, 32'h11223344, w);
      issue(1, 0, 3'd2, 32'h3FC, 0, w);
      issue(1, 1, 3'd0, 32'h3FF, 32'h000000F0, w);
      issue(1, 0, 3'd0, 32'h3FF, 0, w);
      issue(1, 1, 3'd5, 32'h20, 0, w);
      issue(1, 0, 3'd3, 32'h20, 0, w);
      issue(0, 1, 3'd2, 32'h40, 32'hCAFEF00D, w);
      issue(0, 0, 3'd2, 32'h40, 0, w);
      issue(0, 0, 3'd2, 32'h42, 0, w);

      // Both requesters busy: four core grants, then one loader grant.
      CORE_REQ = 1; CORE_WE = 1'($urandom); CORE_FUNCT3 = 3'd2;
      CORE_ADDR = 32'($urandom % 64) << 2; CORE_WDATA = $urandom;
      LDR_REQ = 1; LDR_WE = 1'($urandom);
      LDR_ADDR = 32'($urandom % 64) << 2; LDR_WDATA = $urandom;
      k = 0;
      repeat (20) begin
         @(negedge CLK);
         chk("arb_one_gnt", {31'b0, CORE_GNT & LDR_GNT}, 0);
         chk("arb_any_gnt", {31'b0, CORE_GNT | LDR_GNT}, 1);
         chk("arb_owner_ldr", {31'b0, LDR_GNT}, (k % 5 == 4) ? 1 : 0);
         pc = CORE_GNT;
         pl = LDR_GNT;
         if (pc) on_gnt(1);
         else if (pl) on_gnt(0);
         k++;
         @(posedge CLK); #1;
         if (pc) begin
            CORE_WE = 1'($urandom); CORE_ADDR = 32'($urandom % 64) << 2;
            CORE_WDATA = $urandom;
         end
         if (pl) begin
            LDR_WE = 1'($urandom); LDR_ADDR = 32'($urandom % 64) << 2;
            LDR_WDATA = $urandom;
         end
      end
      CORE_REQ = 0;
      LDR_REQ = 0;

      // Random traffic on both ports.
      pc = 0;
      pl = 0;
      for (int c = 0; c < 400; c++) begin
         if (!pc) begin
            if ($urandom % 10 < 6) begin
               CORE_REQ = 1; CORE_WE = 1'($urandom);
               CORE_FUNCT3 = 3'($urandom % 8); CORE_ADDR = rnd_addr();
               CORE_WDATA = $urandom; pc = 1;
            end else CORE_REQ = 0;
         end
         if (!pl) begin
            if ($urandom % 10 < 4) begin
               LDR_REQ = 1; LDR_WE = 1'($urandom);
               LDR_ADDR = ($urandom % 8 == 0) ? rnd_addr() :
                          (32'($urandom % 64) & 32'hFFFFFFFC);
               LDR_WDATA = $urandom; pl = 1;
            end else LDR_REQ = 0;
         end
         @(negedge CLK);
         chk("rnd_one_gnt", {31'b0, CORE_GNT & LDR_GNT}, 0);
         if (CORE_GNT) begin on_gnt(1); pc = 0; end
         if (LDR_GNT) begin on_gnt(0); pl = 0; end
         @(posedge CLK); #1;
      end
      CORE_REQ = 0;
      LDR_REQ = 0;
      repeat (3) @(posedge CLK);
      #1;

      // Reset asserted during the second half of an sh.
      old31 = ref_mem[10'h31];
      issue(1, 1, 3'd1, 32'h30, 32'h00001234, w);
      RST_N = 1'b0;
      void'(q_core.pop_back());
      ref_mem[10'h31] = old31;
      @(negedge CLK);
      chk("rst_sh2_mem_we", {31'b0, MEM_WE}, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      issue(1, 0, 3'd2, 32'h30, 0, w);
      chk("rst_regrant_wait", w, 0);

      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk("core_queue_drained", q_core.size(), 0);
      chk("ldr_queue_drained", q_ldr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
